// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph constants, nibble codes and FSM states shared by the seven-segment reader
package seven_seg_pkg;
   localparam logic [6:0] GLYPH_0   = 7'h3F;
   localparam logic [6:0] GLYPH_1   = 7'h06;
   localparam logic [6:0] GLYPH_2   = 7'h5B;
   localparam logic [6:0] GLYPH_3   = 7'h4F;
   localparam logic [6:0] GLYPH_4   = 7'h66;
   localparam logic [6:0] GLYPH_5   = 7'h6D;
   localparam logic [6:0] GLYPH_6   = 7'h7D;
   localparam logic [6:0] GLYPH_7   = 7'h07;
   localparam logic [6:0] GLYPH_8   = 7'h7F;
   localparam logic [6:0] GLYPH_9   = 7'h67;
   localparam logic [6:0] GLYPH_A   = 7'h77;
   localparam logic [6:0] GLYPH_B   = 7'h7C;
   localparam logic [6:0] GLYPH_C   = 7'h39;
   localparam logic [6:0] GLYPH_D   = 7'h5E;
   localparam logic [6:0] GLYPH_E   = 7'h79;
   localparam logic [6:0] GLYPH_F   = 7'h71;
   localparam logic [6:0] GLYPH_ERR = 7'h49;
   localparam logic [3:0] NIB_ERR   = 4'hF;
   localparam logic [3:0] NIB_BAD   = 4'hE;
   typedef enum logic {TRACK, HOLD} state_t;
endpackage

// File: rtl/seven_seg_glyph_decode.sv
// seven_seg_glyph_decode: active-high segment pattern to nibble plus legality flag.
// Hex glyphs A-F are legal only when SEVEN_SEG_READER_HEX_EN is defined.
module seven_seg_glyph_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       legal
);
   always_comb begin
      nibble = NIB_BAD;
      legal  = 1'b0;
      case (pattern)
         GLYPH_0:   begin nibble = 4'h0; legal = 1'b1; end
         GLYPH_1:   begin nibble = 4'h1; legal = 1'b1; end
         GLYPH_2:   begin nibble = 4'h2; legal = 1'b1; end
         GLYPH_3:   begin nibble = 4'h3; legal = 1'b1; end
         GLYPH_4:   begin nibble = 4'h4; legal = 1'b1; end
         GLYPH_5:   begin nibble = 4'h5; legal = 1'b1; end
         GLYPH_6:   begin nibble = 4'h6; legal = 1'b1; end
         GLYPH_7:   begin nibble = 4'h7; legal = 1'b1; end
         GLYPH_8:   begin nibble = 4'h8; legal = 1'b1; end
         GLYPH_9:   begin nibble = 4'h9; legal = 1'b1; end
`ifdef SEVEN_SEG_READER_HEX_EN
         GLYPH_A:   begin nibble = 4'hA; legal = 1'b1; end
         GLYPH_B:   begin nibble = 4'hB; legal = 1'b1; end
         GLYPH_C:   begin nibble = 4'hC; legal = 1'b1; end
         GLYPH_D:   begin nibble = 4'hD; legal = 1'b1; end
         GLYPH_E:   begin nibble = 4'hE; legal = 1'b1; end
         GLYPH_F:   begin nibble = 4'hF; legal = 1'b1; end
`endif
         GLYPH_ERR: nibble = NIB_ERR;
         default:   nibble = NIB_BAD;
      endcase
   end
endmodule

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: recovers BCD digits from multiplexed active-low segment drive.
// Define SEVEN_SEG_READER_HEX_EN (via seven_seg_glyph_decode) to accept A-F glyphs.
module seven_seg_reader
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   digit_sel,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] value_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    frame_valid,
   output logic                    sel_error
);
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
   logic [NUM_DIGITS-1:0] samp_sel, seen, seen_next, commit_mask;
   logic [6:0]            samp_seg;
   logic [7:0]            cnt;
   state_t                state, state_next;
   logic                  same, multi, ready, frame_done, legal;
   logic [3:0]            nibble;

   seven_seg_glyph_decode u_decode (
      .pattern(~samp_seg),
      .nibble (nibble),
      .legal  (legal)
   );

   // A commit that coincides with a sample change stays in TRACK so the new pattern can commit later
   always_comb begin
      same        = {digit_sel, seg_in} == {samp_sel, samp_seg};
      multi       = (samp_sel & (samp_sel - NUM_DIGITS'(1))) != '0;
      ready       = state == TRACK && cnt == CNT_MAX && samp_sel != '0 && !multi;
      commit_mask = ready ? samp_sel : '0;
      seen_next   = seen | commit_mask;
      frame_done  = ready && &seen_next;
      state_next  = clear ? TRACK : (ready && same) ? HOLD : !same ? TRACK : state;
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         samp_sel    <= '0;
         samp_seg    <= '0;
         cnt         <= '0;
         state       <= TRACK;
         seen        <= '0;
         value_out   <= '0;
         digit_valid <= '0;
         frame_valid <= 1'b0;
         sel_error   <= 1'b0;
      end else begin
         samp_sel <= digit_sel;
         samp_seg <= seg_in;
         state    <= state_next;
         cnt      <= (clear || !same) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
         if (clear) begin
            seen        <= '0;
            value_out   <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            sel_error   <= 1'b0;
         end else begin
            seen        <= frame_done ? '0 : seen_next;
            frame_valid <= frame_done;
            sel_error   <= sel_error | multi;
            for (int i = 0; i < NUM_DIGITS; i++)
               if (commit_mask[i]) begin
                  value_out[4*i +: 4] <= nibble;
                  digit_valid[i]      <= legal;
               end
         end
      end
endmodule

// File: tb/tb_seven_seg_reader.sv
// tb_seven_seg_reader: table-driven, directed and random checks of seven_seg_reader against a run-length model
module tb_seven_seg_reader;
   localparam int N = 4;
   localparam int S = 4;
`ifdef SEVEN_SEG_READER_HEX_EN
   localparam int NGLYPH = 16;
`else
   localparam int NGLYPH = 10;
`endif
   localparam logic [6:0] GLYPHS [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clock = 1'b0;
   logic reset, clear;
   logic [6:0] seg_in;
   logic [N-1:0] digit_sel;
   logic [4*N-1:0] value_out;
   logic [N-1:0] digit_valid;
   logic frame_valid, sel_error;
   int checks = 0, fails = 0, dut_frames = 0;

   always #5 clock = ~clock;

   seven_seg_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clock(clock), .reset(reset), .seg_in(seg_in), .digit_sel(digit_sel), .clear(clear),
      .value_out(value_out), .digit_valid(digit_valid), .frame_valid(frame_valid), .sel_error(sel_error)
   );

   // Reference model: run length of identical inputs; a pattern commits on the edge after its S-th sample
   logic [N-1:0] m_sel, m_valid, m_seen;
   logic [6:0] m_seg;
   logic [3:0] m_val [N];
   logic m_frame, m_err;
   int m_run;

   function automatic logic [4:0] ref_decode(input logic [6:0] seg_low);
      logic [6:0] p = ~seg_low;
      if (p == 7'h49) return 5'h0F;
      for (int d = 0; d < NGLYPH; d++) if (GLYPHS[d] == p) return {1'b1, 4'(d)};
      return 5'h0E;
   endfunction

   task automatic model_reset();
      m_sel = '0; m_seg = '0; m_run = 1; m_valid = '0; m_seen = '0; m_frame = 0; m_err = 0;
      for (int i = 0; i < N; i++) m_val[i] = 4'h0;
   endtask

   task automatic model_edge(input logic [N-1:0] sel, input logic [6:0] seg, input logic clr);
      logic [4:0] d;
      m_frame = 0;
      if (clr) begin
         m_valid = '0; m_seen = '0; m_err = 0;
         for (int i = 0; i < N; i++) m_val[i] = 4'h0;
      end else begin
         if (m_run == S && $onehot(m_sel)) begin
            d = ref_decode(m_seg);
            for (int i = 0; i < N; i++)
               if (m_sel[i]) begin m_val[i] = d[3:0]; m_valid[i] = d[4]; m_seen[i] = 1'b1; end
            if (&m_seen) begin m_frame = 1; m_seen = '0; end
         end
         if ($countones(m_sel) > 1) m_err = 1;
      end
      m_run = (clr || {sel, seg} != {m_sel, m_seg}) ? 1 : (m_run < 1000 ? m_run + 1 : m_run);
      m_sel = sel; m_seg = seg;
   endtask

   task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic check_model();
      logic [4*N-1:0] ev;
      for (int i = 0; i < N; i++) ev[4*i +: 4] = m_val[i];
      checks++;
      if (value_out !== ev || digit_valid !== m_valid || frame_valid !== m_frame || sel_error !== m_err) begin
         fails++;
         $display("FAIL model @%0t: got val=%h valid=%b frame=%b err=%b, expected val=%h valid=%b frame=%b err=%b",
                  $time, value_out, digit_valid, frame_valid, sel_error, ev, m_valid, m_frame, m_err);
      end
   endtask

   task automatic step(input logic [N-1:0] sel, input logic [6:0] seg, input logic clr);
      digit_sel = sel; seg_in = seg; clear = clr;
      @(posedge clock);
      model_edge(sel, seg, clr);
      #1;
      if (frame_valid) dut_frames++;
      check_model();
   endtask

   task automatic hold(input logic [N-1:0] sel, input logic [6:0] seg, input int n);
      for (int k = 0; k < n; k++) step(sel, seg, 1'b0);
   endtask

   typedef struct { logic [N-1:0] sel; logic [6:0] pat; logic [3:0] nib; logic ok; } vec_t;
   vec_t vecs [12];

   initial begin
      int f0, idx;
      logic [4*N-1:0] saved;
      logic [3:0] s0;
      logic [N-1:0] rsel;
      logic [6:0] rpat;
      vecs[0]  = '{4'b0001, 7'h3F, 4'h0, 1'b1};
      vecs[1]  = '{4'b0010, 7'h7D, 4'h6, 1'b1};
      vecs[2]  = '{4'b0100, 7'h07, 4'h7, 1'b1};
      vecs[3]  = '{4'b1000, 7'h67, 4'h9, 1'b1};
      vecs[4]  = '{4'b0001, 7'h6D, 4'h5, 1'b1};
      vecs[5]  = '{4'b0010, 7'h49, 4'hF, 1'b0};
      vecs[6]  = '{4'b0100, 7'h00, 4'hE, 1'b0};
      vecs[7]  = '{4'b1000, 7'h7F, 4'h8, 1'b1};
`ifdef SEVEN_SEG_READER_HEX_EN
      vecs[8]  = '{4'b0001, 7'h77, 4'hA, 1'b1};
      vecs[9]  = '{4'b0010, 7'h5E, 4'hD, 1'b1};
`else
      vecs[8]  = '{4'b0001, 7'h77, 4'hE, 1'b0};
      vecs[9]  = '{4'b0010, 7'h5E, 4'hE, 1'b0};
`endif
      vecs[10] = '{4'b0100, 7'h7E, 4'hE, 1'b0};
      vecs[11] = '{4'b1000, 7'h4F, 4'h3, 1'b1};

      reset = 1; clear = 0; digit_sel = '0; seg_in = '0;
      repeat (2) @(posedge clock);
      #1;
      expect_eq("reset value_out", 32'(value_out), 0);
      expect_eq("reset digit_valid", 32'(digit_valid), 0);
      expect_eq("reset frame_valid", 32'(frame_valid), 0);
      expect_eq("reset sel_error", 32'(sel_error), 0);
      model_reset();
      reset = 0;

      f0 = dut_frames;
      hold(4'b0001, ~7'h06, 8);
      hold(4'b0010, ~7'h5B, 8);
      hold(4'b0100, ~7'h4F, 8);
      hold(4'b1000, ~7'h66, 8);
      expect_eq("frame value_out", 32'(value_out), 32'h4321);
      expect_eq("frame digit_valid", 32'(digit_valid), 32'hF);
      expect_eq("frame pulse count", dut_frames - f0, 1);

      for (int i = 0; i < 12; i++) begin
         hold(vecs[i].sel, ~vecs[i].pat, 6);
         idx = 0;
         for (int j = 0; j < N; j++) if (vecs[i].sel[j]) idx = j;
         expect_eq($sformatf("table%0d nibble", i), 32'(value_out[4*idx +: 4]), 32'(vecs[i].nib));
         expect_eq($sformatf("table%0d valid", i), 32'(digit_valid[idx]), 32'(vecs[i].ok));
      end

      s0 = value_out[3:0];
      hold(4'b0001, ~7'h3F, 3);
      step(4'b0000, ~7'h3F, 1'b0);
      expect_eq("glitch no commit", 32'(value_out[3:0]), 32'(s0));
      for (int k = 1; k <= 5; k++) begin
         step(4'b0001, ~7'h3F, 1'b0);
         expect_eq($sformatf("latency edge%0d", k), 32'(value_out[3:0]), k < 5 ? 32'(s0) : 0);
      end
      hold(4'b0001, ~7'h3F, 20);
      expect_eq("held slot0", 32'(value_out[3:0]), 0);
      expect_eq("held valid0", 32'(digit_valid[0]), 1);

      hold(4'b0100, ~7'h49, 6);
      expect_eq("err glyph nibble", 32'(value_out[11:8]), 32'hF);
      expect_eq("err glyph valid", 32'(digit_valid[2]), 0);
      hold(4'b0100, ~7'h00, 6);
      expect_eq("blank glyph nibble", 32'(value_out[11:8]), 32'hE);
      expect_eq("blank glyph valid", 32'(digit_valid[2]), 0);

      saved = value_out;
      hold(4'b0110, ~7'h3F, 10);
      expect_eq("multi sel_error", 32'(sel_error), 1);
      expect_eq("multi no slot change", 32'(value_out), 32'(saved));
      step(4'b0000, ~7'h7F, 1'b1);
      expect_eq("clear sel_error", 32'(sel_error), 0);
      expect_eq("clear value_out", 32'(value_out), 0);
      expect_eq("clear digit_valid", 32'(digit_valid), 0);

      hold(4'b0001, ~7'h77, 6);
`ifdef SEVEN_SEG_READER_HEX_EN
      expect_eq("hex A nibble", 32'(value_out[3:0]), 32'hA);
      expect_eq("hex A valid", 32'(digit_valid[0]), 1);
`else
      expect_eq("hex A nibble", 32'(value_out[3:0]), 32'hE);
      expect_eq("hex A valid", 32'(digit_valid[0]), 0);
`endif

      hold(4'b1000, ~7'h7F, 3);
      #2 reset = 1;
      #1;
      expect_eq("async reset value_out", 32'(value_out), 0);
      expect_eq("async reset digit_valid", 32'(digit_valid), 0);
      expect_eq("async reset sel_error", 32'(sel_error), 0);
      model_reset();
      #1 reset = 0;
      hold(4'b1000, ~7'h7F, S);
      expect_eq("post reset no early commit", 32'(value_out[15:12]), 0);
      step(4'b1000, ~7'h7F, 1'b0);
      expect_eq("post reset commit", 32'(value_out[15:12]), 32'h8);

      for (int k = 0; k < 400; k++) begin
         int r = $urandom_range(0, 19);
         rsel = r < 14 ? N'(1 << $urandom_range(0, N - 1)) : r < 17 ? '0 : N'($urandom);
         rpat = $urandom_range(0, 3) == 0 ? 7'($urandom) : GLYPHS[$urandom_range(0, 15)];
         for (int j = $urandom_range(1, 8); j > 0; j--) step(rsel, ~rpat, $urandom_range(0, 60) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/seven_seg_reader.md
# seven_seg_reader

Decodes multiplexed, active-low seven-segment display drive back into BCD digits. It is the receive-side counterpart of the segment encoders that drive the board's displays. It monitors a shared segment bus plus one-hot digit strobes, waits until each digit's pattern is stable, and maps the pattern back to a nibble. It assembles a full multi-digit value with per-digit validity and a frame-complete pulse, for display self-check and for score readback in the maze game.

## Interface
Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1–8)
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed (2–255)

Ports:
- clock  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- seg_in  input  7  segment drive, active-low; bit0=a … bit6=g
- digit_sel  input  NUM_DIGITS  one-hot, active-high strobe naming the digit currently on seg_in
- clear  input  1  synchronous clear of slots, validity, seen mask and sel_error
- value_out  output  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i]
- digit_valid  output  NUM_DIGITS  bit i set when slot i holds a legal glyph
- frame_valid  output  1  one-cycle pulse when every digit has been committed since the last pulse
- sel_error  output  1  sticky; set when digit_sel has more than one bit high

## Operation
- Input stage: {digit_sel, seg_in} is registered every cycle into the sample register.
- Stability counter: it increments, saturating at STABLE_CYCLES-1, when the new sample equals the held sample. It resets to 0 on any difference.
- FSM states: TRACK, HOLD.
  - TRACK → HOLD when the counter reaches STABLE_CYCLES-1 and digit_sel is exactly one-hot. The commit happens on that transition.
  - HOLD → TRACK on any sample change. A held pattern is never committed twice.
- Commit to slot i (the one-hot index):
  - Segments are inverted to active-high, then decoded.
  - Legal glyphs: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x67→9.
  - Error glyph 0x49 → nibble 0xF, digit_valid[i]=0.
  - Any other pattern → nibble 0xE, digit_valid[i]=0.
  - A legal glyph sets digit_valid[i]=1.
  - seen[i] is set regardless of legality.
- Frame completion: when seen becomes all-ones, frame_valid pulses for 1 cycle and seen clears in the same edge.
- digit_sel all-zero is display blanking: no commit, no error, and the counter still tracks.
- digit_sel with more than one bit high: no commit, and sel_error is set until clear or reset.
- clear has priority over a commit in the same cycle. After clear, the FSM returns to TRACK with the counter at 0.

## Timing
- Reset values:
  - value_out=0, digit_valid=0, frame_valid=0, sel_error=0.
  - seen=0, counter=0, sample register=0, FSM=TRACK.
- Latency: a pattern present at STABLE_CYCLES consecutive rising edges appears on value_out/digit_valid after edge STABLE_CYCLES+1, counted from the first of those edges.
- frame_valid asserts on the same edge as the final slot update.
- A change at any edge restarts the count. A glitch of one cycle never commits.
- Reset asserted mid-count discards all partial state immediately (asynchronously).

## Configuration
- SEVEN_SEG_READER_HEX_EN defined:
  - A–F also decode as legal glyphs: 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F.
  - Each sets digit_valid.
- Undefined: those six patterns are illegal and decode to 0xE with digit_valid=0.
- Either way, 0x49 remains the error glyph.

## Structure
- Shared package seven_seg_pkg holds:
  - the glyph constants (GLYPH_0 … GLYPH_9, GLYPH_A … GLYPH_F, GLYPH_ERR);
  - the nibble codes NIB_ERR=0xF and NIB_BAD=0xE;
  - the FSM state typedef.
- Sub-module seven_seg_glyph_decode: purely combinational. Active-high pattern in → nibble + legal flag out; it honours SEVEN_SEG_READER_HEX_EN.
- The top level owns the sample register, counter, FSM, slot registers, seen mask and flags.

## Test plan
- Digits 1,2,3,4 driven on digit_sel 0001,0010,0100,1000 with patterns ~0x06, ~0x5B, ~0x4F, ~0x66, each held 8 cycles (STABLE_CYCLES=4) -> value_out=0x4321, digit_valid=1111, exactly one frame_valid pulse on the 4th commit.
- Digit 0 held at ~0x3F for 3 cycles then changed -> no commit; hold 5 cycles -> commit exactly 5 edges after the first sample, with no second commit while held 20 cycles.
- seg_in=~0x49 on digit 2 -> slot 2 = 0xF, digit_valid[2]=0; seg_in=~0x00 -> slot = 0xE, invalid.
- digit_sel=0110 for 10 cycles -> sel_error=1, no slot change; clear -> sel_error=0 and all slots 0.
- With SEVEN_SEG_READER_HEX_EN defined, ~0x77 -> nibble 0xA, valid; without it -> 0xE, invalid.
- reset pulsed while a stable digit is at count 2 -> all outputs 0; after release, the same pattern needs a full STABLE_CYCLES again.
